// File: rtl/ulpi_reg_monitor_pkg.sv
// ulpi_reg_monitor_pkg: scan FSM states and ULPI register addresses.
// Shared by ulpi_reg_monitor and led_rotator.
package ulpi_reg_monitor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] VID_LO    = 8'h00;
  localparam logic [7:0] VID_HI    = 8'h01;
  localparam logic [7:0] PID_LO    = 8'h02;
  localparam logic [7:0] PID_HI    = 8'h03;
  localparam logic [7:0] FUNC_CTRL = 8'h04;

endpackage

// File: rtl/ulpi_reg_monitor_led_rotator.sv
// led_rotator: free-running dwell counter that steps through the
// snapshot entries and muxes the selected byte onto the LEDs.
module led_rotator
  import ulpi_reg_monitor_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int DWELL_W  = 26,
  parameter int SEL_W    = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REGS*DATA_W-1:0] snap_i,
  output logic [DATA_W-1:0]          led_o,
  output logic [SEL_W-1:0]           led_sel_o
);

  logic [DWELL_W-1:0] dwell_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dwell_q   <= '0;
      led_sel_o <= '0;
    end else begin
      dwell_q <= dwell_q + 1'b1;
      if (&dwell_q) begin
        if (led_sel_o == SEL_W'(NUM_REGS - 1))
          led_sel_o <= '0;
        else
          led_sel_o <= led_sel_o + 1'b1;
      end
    end
  end

  always_comb begin
    led_o = snap_i[DATA_W-1:0];
    for (int i = 0; i < NUM_REGS; i++)
      if (led_sel_o == SEL_W'(i))
        led_o = snap_i[i*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/ulpi_reg_monitor.sv
// ulpi_reg_monitor: scans a list of ULPI PHY registers into a snapshot.
// Define ULPI_REG_MONITOR_WRITE_EN for an initial PHY write after reset.
module ulpi_reg_monitor
  import ulpi_reg_monitor_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter logic [NUM_REGS*ADDR_W-1:0] REG_ADDRS =
    {FUNC_CTRL, PID_LO, VID_HI, VID_LO},
  parameter int TIMEOUT  = 255,
  parameter int DWELL_W  = 26,
  parameter logic [ADDR_W-1:0] INIT_WR_ADDR = FUNC_CTRL,
  parameter logic [DATA_W-1:0] INIT_WR_DATA = 8'h48,
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       auto_i,
  output logic [ADDR_W-1:0]          reg_addr_o,
  output logic                       reg_stb_o,
  output logic                       reg_we_o,
  output logic [DATA_W-1:0]          reg_data_o,
  input  logic [DATA_W-1:0]          reg_data_i,
  input  logic                       reg_ack_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       timeout_o,
  output logic [NUM_REGS*DATA_W-1:0] snap_o,
  output logic [DATA_W-1:0]          led_o,
  output logic [SEL_W-1:0]           led_sel_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [SEL_W-1:0] idx;
  logic [TMO_W-1:0] tcnt;
  logic             tmo_hit;

  assign tmo_hit = (tcnt == TMO_W'(TIMEOUT - 1));

`ifdef ULPI_REG_MONITOR_WRITE_EN
  logic first_q;
`else
  logic unused_wr;
  assign unused_wr  = ^{INIT_WR_ADDR, INIT_WR_DATA};
  assign reg_we_o   = 1'b0;
  assign reg_data_o = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      idx        <= '0;
      tcnt       <= '0;
      reg_addr_o <= '0;
      reg_stb_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      timeout_o  <= 1'b0;
      snap_o     <= '1;
`ifdef ULPI_REG_MONITOR_WRITE_EN
      reg_we_o   <= 1'b0;
      reg_data_o <= '0;
      first_q    <= 1'b1;
`endif
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i || auto_i) begin
            busy_o    <= 1'b1;
            timeout_o <= 1'b0;
            idx       <= '0;
`ifdef ULPI_REG_MONITOR_WRITE_EN
            state     <= first_q ? S_WR_ISSUE : S_RD_ISSUE;
            first_q   <= 1'b0;
`else
            state     <= S_RD_ISSUE;
`endif
          end
        end
`ifdef ULPI_REG_MONITOR_WRITE_EN
        S_WR_ISSUE: begin
          if (!reg_ack_i) begin
            reg_addr_o <= INIT_WR_ADDR;
            reg_data_o <= INIT_WR_DATA;
            reg_we_o   <= 1'b1;
            reg_stb_o  <= 1'b1;
            tcnt       <= '0;
            state      <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (reg_ack_i || tmo_hit) begin
            if (!reg_ack_i)
              timeout_o <= 1'b1;
            reg_stb_o <= 1'b0;
            reg_we_o  <= 1'b0;
            idx       <= '0;
            state     <= S_RD_ISSUE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
`endif
        S_RD_ISSUE: begin
          // a stale ack must clear before a new strobe goes out
          if (!reg_ack_i) begin
            reg_addr_o <= REG_ADDRS[idx*ADDR_W +: ADDR_W];
            reg_stb_o  <= 1'b1;
            tcnt       <= '0;
            state      <= S_RD_WAIT;
`ifdef ULPI_REG_MONITOR_WRITE_EN
            reg_we_o   <= 1'b0;
`endif
          end
        end
        S_RD_WAIT: begin
          if (reg_ack_i || tmo_hit) begin
            snap_o[idx*DATA_W +: DATA_W] <=
              reg_ack_i ? reg_data_i : {DATA_W{1'b1}};
            if (!reg_ack_i)
              timeout_o <= 1'b1;
            reg_stb_o <= 1'b0;
            if (idx == SEL_W'(NUM_REGS - 1)) begin
              done_o <= 1'b1;
              state  <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_RD_ISSUE;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  led_rotator #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .DWELL_W  (DWELL_W),
    .SEL_W    (SEL_W)
  ) u_led (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .snap_i    (snap_o),
    .led_o     (led_o),
    .led_sel_o (led_sel_o)
  );

endmodule
